// File: rtl/din_filter.sv
// Digital input conditioner: 2-flop synchroniser, optional inversion, debounce,
// and frame-snapshotted sticky edge latches (enabled by DIN_FILTER_EDGE_LATCH_EN).
module din_filter #(
  parameter int                  CHANNELS        = 8,
  parameter int                  DEBOUNCE_CYCLES = 4800,
  parameter int                  CNT_WIDTH       = 16,
  parameter logic [CHANNELS-1:0] INVERT_MASK     = CHANNELS'('h1F)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] din,
  input  logic                frame_done,
  output logic [CHANNELS-1:0] state,
  output logic [CHANNELS-1:0] snap_state,
  output logic [CHANNELS-1:0] snap_rise,
  output logic [CHANNELS-1:0] snap_fall
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0] sync1_reg;
  logic [CHANNELS-1:0] sync2_reg;
  logic [CHANNELS-1:0] stable_reg;
  logic [CHANNELS-1:0] stable_next;
  logic [CHANNELS-1:0] snap_state_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg      <= '0;
      sync2_reg      <= '0;
      stable_reg     <= '0;
      snap_state_reg <= '0;
    end else begin
      sync1_reg  <= din;
      sync2_reg  <= sync1_reg ^ INVERT_MASK;
      stable_reg <= stable_next;
      if (frame_done) snap_state_reg <= stable_next;
    end
  end

  // Per-channel debounce: a level is accepted only after DEBOUNCE_CYCLES
  // consecutive mismatching samples; any match restarts the count.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [CNT_WIDTH-1:0] cnt_reg;
      logic [CNT_WIDTH-1:0] cnt_next;
      logic                 stb_next;

      always_comb begin
        cnt_next = '0;
        stb_next = stable_reg[gi];
        if (sync2_reg[gi] != stable_reg[gi]) begin
          if (cnt_reg == CNT_LAST) stb_next = sync2_reg[gi];
          else                     cnt_next = cnt_reg + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) cnt_reg <= '0;
        else     cnt_reg <= cnt_next;
      end

      assign stable_next[gi] = stb_next;
    end
  endgenerate

  assign state      = stable_reg;
  assign snap_state = snap_state_reg;

`ifdef DIN_FILTER_EDGE_LATCH_EN
  logic [CHANNELS-1:0] rise_evt;
  logic [CHANNELS-1:0] fall_evt;
  logic [CHANNELS-1:0] rise_lat_reg;
  logic [CHANNELS-1:0] fall_lat_reg;
  logic [CHANNELS-1:0] snap_rise_reg;
  logic [CHANNELS-1:0] snap_fall_reg;

  assign rise_evt = stable_next & ~stable_reg;
  assign fall_evt = ~stable_next & stable_reg;

  // An event on the frame_done edge goes straight into the snapshot and is
  // not left in the latch, so it is reported exactly once.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_lat_reg  <= '0;
      fall_lat_reg  <= '0;
      snap_rise_reg <= '0;
      snap_fall_reg <= '0;
    end else if (frame_done) begin
      snap_rise_reg <= rise_lat_reg | rise_evt;
      snap_fall_reg <= fall_lat_reg | fall_evt;
      rise_lat_reg  <= '0;
      fall_lat_reg  <= '0;
    end else begin
      rise_lat_reg <= rise_lat_reg | rise_evt;
      fall_lat_reg <= fall_lat_reg | fall_evt;
    end
  end

  assign snap_rise = snap_rise_reg;
  assign snap_fall = snap_fall_reg;
`else
  assign snap_rise = '0;
  assign snap_fall = '0;
`endif

endmodule

// File: tb/tb_din_filter.sv
// Self-checking bench for din_filter: directed scenarios plus randomized traffic
// against a sample-window reference model.
module tb_din_filter;

  localparam int         CH   = 8;
  localparam int         D    = 4;
  localparam logic [7:0] MASK = 8'h1F;
`ifdef DIN_FILTER_EDGE_LATCH_EN
  localparam bit LATCH_EN = 1'b1;
`else
  localparam bit LATCH_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [CH-1:0] din = '0;
  logic         frame_done = 1'b0;
  logic [CH-1:0] state, snap_state, snap_rise, snap_fall;

  int vectors = 0;
  int miscompares = 0;

  din_filter #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(16), .INVERT_MASK(MASK)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .frame_done(frame_done),
    .state(state), .snap_state(snap_state), .snap_rise(snap_rise), .snap_fall(snap_fall)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last D conditioned samples
  // all disagree with the current accepted level.
  logic [7:0]   m_sync1, m_sync2, m_stable, m_rlat, m_flat;
  logic [7:0]   m_snap_state, m_snap_rise, m_snap_fall;
  logic [D-1:0] m_hist [CH];

  task automatic model_clear();
    m_sync1 = '0; m_sync2 = '0; m_stable = '0; m_rlat = '0; m_flat = '0;
    m_snap_state = '0; m_snap_rise = '0; m_snap_fall = '0;
    for (int i = 0; i < CH; i++) m_hist[i] = '0;
  endtask

  task automatic cycle(input logic r, input logic [7:0] d, input logic f);
    logic [7:0]   n_stable, rev, fev;
    logic [D-1:0] nh;
    logic [7:0]   exp_r, exp_f;
    @(negedge clk);
    rst = r; din = d; frame_done = f;
    @(posedge clk);
    #1;
    if (r) begin
      model_clear();
    end else begin
      n_stable = m_stable;
      for (int i = 0; i < CH; i++) begin
        nh = {m_hist[i][D-2:0], m_sync2[i]};
        m_hist[i] = nh;
        if (nh == {D{~m_stable[i]}}) n_stable[i] = ~m_stable[i];
      end
      rev = n_stable & ~m_stable;
      fev = ~n_stable & m_stable;
      if (f) begin
        m_snap_state = n_stable;
        m_snap_rise  = m_rlat | rev;
        m_snap_fall  = m_flat | fev;
        m_rlat = '0; m_flat = '0;
      end else begin
        m_rlat |= rev; m_flat |= fev;
      end
      m_stable = n_stable;
      m_sync2  = m_sync1 ^ MASK;
      m_sync1  = d;
    end
    exp_r = LATCH_EN ? m_snap_rise : 8'h00;
    exp_f = LATCH_EN ? m_snap_fall : 8'h00;
    vectors += 4;
    if (state !== m_stable) begin
      miscompares++;
      $display("FAIL state t=%0t got=%h exp=%h", $time, state, m_stable);
    end
    if (snap_state !== m_snap_state) begin
      miscompares++;
      $display("FAIL snap_state t=%0t got=%h exp=%h", $time, snap_state, m_snap_state);
    end
    if (snap_rise !== exp_r) begin
      miscompares++;
      $display("FAIL snap_rise t=%0t got=%h exp=%h", $time, snap_rise, exp_r);
    end
    if (snap_fall !== exp_f) begin
      miscompares++;
      $display("FAIL snap_fall t=%0t got=%h exp=%h", $time, snap_fall, exp_f);
    end
  endtask

  task automatic settle(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, d, 1'b0);
    cycle(1'b0, d, 1'b1);
  endtask

  task automatic test_reset();
    model_clear();
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b1, 8'hA5, 1'b1);
    vectors++;
    if ({state, snap_state, snap_rise, snap_fall} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h exp=0", {state, snap_state, snap_rise, snap_fall});
    end
    $display("test_reset done");
  endtask

  task automatic test_invert();
    settle(8'h00, 10);
    vectors++;
    if (state !== 8'h1F) begin
      miscompares++;
      $display("FAIL invert_low got=%h exp=1f", state);
    end
    settle(8'hFF, 10);
    vectors++;
    if (state !== 8'hE0) begin
      miscompares++;
      $display("FAIL invert_high got=%h exp=e0", state);
    end
    settle(8'h00, 10);
    $display("test_invert done");
  endtask

  task automatic test_latency();
    for (int i = 0; i < D + 1; i++) cycle(1'b0, 8'h20, 1'b0);
    vectors++;
    if (state[5] !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early got=%b exp=0", state[5]);
    end
    cycle(1'b0, 8'h20, 1'b0);
    vectors++;
    if (state[5] !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_exact got=%b exp=1", state[5]);
    end
    settle(8'h00, 10);
    $display("test_latency done");
  endtask

  task automatic test_glitch();
    int  fall_n;
    bit  seen_high, glitch_seen;
    glitch_seen = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h40, 1'b0);
      if (state[6]) glitch_seen = 1;
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      if (state[6]) glitch_seen = 1;
    end
    vectors++;
    if (glitch_seen) begin
      miscompares++;
      $display("FAIL glitch_3cyc got=1 exp=0");
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h40, 1'b0);
    seen_high = 0; fall_n = -1;
    for (int n = 1; n <= 20; n++) begin
      cycle(1'b0, 8'h00, 1'b0);
      if (state[6]) seen_high = 1;
      else if (seen_high && fall_n < 0) fall_n = n;
    end
    vectors++;
    if (!seen_high || fall_n != 6) begin
      miscompares++;
      $display("FAIL pulse_4cyc seen_high=%0d fall_after=%0d exp=1/6", seen_high, fall_n);
    end
    settle(8'h00, 4);
    $display("test_glitch done");
  endtask

  task automatic test_latch();
    settle(8'h00, 6);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h04, 1'b0);
    settle(8'h00, 10);
    vectors++;
    if (snap_rise !== (LATCH_EN ? 8'h04 : 8'h00) || snap_fall !== (LATCH_EN ? 8'h04 : 8'h00)
        || snap_state !== 8'h1F) begin
      miscompares++;
      $display("FAIL latch_pulse got=%h/%h/%h exp=%h/%h/1f", snap_rise, snap_fall, snap_state,
               LATCH_EN ? 8'h04 : 8'h00, LATCH_EN ? 8'h04 : 8'h00);
    end
    settle(8'h00, 3);
    vectors++;
    if (snap_rise !== 8'h00 || snap_fall !== 8'h00) begin
      miscompares++;
      $display("FAIL latch_cleared got=%h/%h exp=00/00", snap_rise, snap_fall);
    end
    $display("test_latch done");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < D + 1; i++) cycle(1'b0, 8'h20, 1'b0);
    cycle(1'b0, 8'h20, 1'b1);
    vectors++;
    if (snap_rise !== (LATCH_EN ? 8'h20 : 8'h00) || snap_state[5] !== 1'b1) begin
      miscompares++;
      $display("FAIL coincident got=%h/%b exp=%h/1", snap_rise, snap_state[5],
               LATCH_EN ? 8'h20 : 8'h00);
    end
    cycle(1'b0, 8'h20, 1'b1);
    vectors++;
    if (snap_rise !== 8'h00) begin
      miscompares++;
      $display("FAIL back_to_back got=%h exp=00", snap_rise);
    end
    settle(8'h00, 10);
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    int rise_n;
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h40, 1'b0);
    cycle(1'b1, 8'h40, 1'b0);
    rise_n = -1;
    for (int n = 1; n <= 12; n++) begin
      cycle(1'b0, 8'h40, 1'b0);
      if (state[6] && rise_n < 0) rise_n = n;
    end
    vectors++;
    if (rise_n != 6) begin
      miscompares++;
      $display("FAIL reset_mid rise_after=%0d exp=6", rise_n);
    end
    settle(8'h00, 10);
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       f, r;
    d = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 5) == 0) d[i] = ~d[i];
      f = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 499) == 0);
      cycle(r, d, f);
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_invert();
    test_latency();
    test_glitch();
    test_latch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
